// File: rtl/flux_write_arbiter.sv
// Purpose: per-flux one-word holding registers feeding a round-robin arbiter that drives one tagged FIFO write stream.
// Latency: 2 cycles minimum from acceptance to write=1 (load edge, then grant edge).
// Backpressure: a full flux is never granted, so its held word blocks only that flux's in_ready; other fluxes keep flowing.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   in_valid  per-flux producer valid
//   in_data   per-flux payloads, flux i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready  per-flux ready (holding register empty)
//   din       tagged word to the FIFO, {flux id, payload}
//   write     FIFO write strobe, one word per cycle at most
//   full      per-flux full from the FIFO
module flux_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int FLUX       = 2,
    localparam int FLUX_BITS = $clog2(FLUX)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [FLUX-1:0]                 in_valid,
    input  logic [FLUX*DATA_WIDTH-1:0]      in_data,
    output logic [FLUX-1:0]                 in_ready,
    output logic [DATA_WIDTH+FLUX_BITS-1:0] din,
    output logic                            write,
    input  logic [FLUX-1:0]                 full
);

    logic [FLUX-1:0]       hold_valid;
    logic [DATA_WIDTH-1:0] hold_data [FLUX];
    logic [FLUX_BITS-1:0]  rr_ptr;

    logic [FLUX-1:0]       elig;
    logic                  grant_vld;
    logic [FLUX_BITS-1:0]  grant_idx;
    logic [FLUX_BITS-1:0]  scan_idx;
    logic [FLUX_BITS-1:0]  ptr_next;
    logic [FLUX_BITS-1:0]  din_tag;

    assign din_tag = din[DATA_WIDTH +: FLUX_BITS];

    // Ready depends only on registered state, never on full.
    assign in_ready = ~hold_valid;

    // The FIFO's full flag cannot yet account for the word currently on
    // din, so the flux that owns it sits out this cycle.
    always_comb begin
        elig = '0;
        for (int i = 0; i < FLUX; i++) begin
            elig[i] = hold_valid[i] && !full[i] &&
                      !(write && (din_tag == FLUX_BITS'(i)));
        end
    end

    // Round-robin scan starting at rr_ptr; first eligible flux wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < FLUX; k++) begin
            scan_idx = FLUX_BITS'((int'(rr_ptr) + k) % FLUX);
            if (!grant_vld && elig[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    // Explicit wrap keeps non-power-of-two FLUX values correct.
    assign ptr_next = (grant_idx == FLUX_BITS'(FLUX - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid <= '0;
            for (int i = 0; i < FLUX; i++) begin
                hold_data[i] <= '0;
            end
            write  <= 1'b0;
            din    <= '0;
            rr_ptr <= '0;
        end else begin
            // Loads only land in empty slots and grants only drain full ones,
            // so the two never collide on the same flux.
            for (int i = 0; i < FLUX; i++) begin
                if (in_valid[i] && !hold_valid[i]) begin
                    hold_valid[i] <= 1'b1;
                    hold_data[i]  <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (grant_vld) begin
                write                 <= 1'b1;
                din                   <= {grant_idx, hold_data[grant_idx]};
                hold_valid[grant_idx] <= 1'b0;
                rr_ptr                <= ptr_next;
            end else begin
                // din keeps its last word; only the strobe drops.
                write <= 1'b0;
            end
        end
    end

endmodule
